countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
//
// PURPOSE
//   Loadable down-counter with expiry handshake, the counterpart to the
//   free-running up-counter. It holds a programmed tick count and decrements
//   it on each enabled cycle. At zero it raises an expiry flag and holds it
//   until the consumer acknowledges. It drives timeouts and interval timing
//   alongside the counter logic in the same clock domain.
//
// PARAMETERS
//   WIDTH        8   counter / load value width in bits
//   AUTO_RELOAD  0   1 = reload last loaded value on expiry and keep running
//
// PORTS
//   clk           in   1      rising-edge clock; single clock domain
//   reset         in   1      synchronous, active-high reset
//   load          in   1      pulse: capture load_value into count and reload reg
//   load_value    in   WIDTH  value captured on load
//   start         in   1      pulse: begin counting from the current count
//   enable        in   1      decrement qualifier while running
//   ack           in   1      clears expired (AUTO_RELOAD=0 only)
//   count         out  WIDTH  current count (registered)
//   busy          out  1      1 while state==RUN
//   zero_reached  out  1      combinational: count == 0
//   expired       out  1      expiry flag (registered)
//
// BEHAVIOUR
//   Reset:
//   - State IDLE; count=0, reload reg=0, busy=0, expired=0, zero_reached=1.
//   - Reset overrides every other input in the same cycle, including
//     mid-count and while expired is held.
//   States: IDLE, RUN, EXPIRED (binary encoded; no other reachable state).
//   IDLE:
//   - load: count<=load_value and reload<=load_value; stay IDLE.
//   - start with count!=0: go to RUN next edge. start with count==0: ignored.
//   - load+start in the same cycle: load applies first; go to RUN only if
//     load_value!=0.
//   RUN:
//   - enable=1: count<=count-1 each cycle. enable=0: count holds.
//   - count==1 with enable=1:
//       AUTO_RELOAD=0 -> count<=0, state<=EXPIRED, expired<=1 on the same edge.
//       AUTO_RELOAD=1 -> count<=reload, stay RUN, expired is a 1-cycle pulse.
//   - load in RUN restarts the count: count<=load_value, reload<=load_value.
//     If load_value==0, go to IDLE with no expiry.
//   - load and the terminal decrement in the same cycle: load wins; no expiry.
//   - start in RUN is ignored.
//   - AUTO_RELOAD=1 with reload==0 cannot reach RUN, because start requires
//     count!=0.
//   EXPIRED (AUTO_RELOAD=0 only):
//   - expired=1 and count=0 held until ack.
//   - ack: state<=IDLE and expired<=0 on the next edge.
//   - load in EXPIRED updates count/reload but state stays EXPIRED until ack.
//   - start in EXPIRED is ignored.
//   Arithmetic and latency:
//   - Count is unsigned; it never wraps below 0 (decrement only in RUN with
//     count!=0).
//   - Latency: start sampled at edge t -> RUN at t. With enable held high,
//     expired rises at edge t+N for a loaded value N (count N..1 over N edges).
//   - busy=0 in IDLE and EXPIRED. zero_reached tracks count combinationally.
//
// TESTING
//   1. Reset then idle 5 cycles -> count=0, busy=0, expired=0, zero_reached=1.
//   2. load 5, start, enable=1 -> count 5,4,3,2,1,0; expired rises 5 edges
//      after start; held 10 cycles; ack -> IDLE, expired=0 next cycle.
//   3. load 4, start, enable toggling 1,0,1,0 -> count decrements only on
//      enabled cycles; expired after exactly 4 enabled cycles.
//   4. In RUN at count=2, load 7 -> count=7, busy=1, no expiry. At count=1
//      with enable, load 3 in the same cycle -> count=3, no expired pulse.
//   5. start with count=0 -> stays IDLE. load 0 + start same cycle -> IDLE.
//      reset asserted mid-RUN at count=3 -> IDLE, count=0 next edge.
//   6. AUTO_RELOAD=1, load 3, start, enable=1 for 10 cycles -> expired pulses
//      every 3 cycles, count sequence 3,2,1,3,2,1..., busy stays 1.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Purpose:
//   Loadable down-counter with an expiry handshake. A programmed tick count is
//   decremented on each enabled cycle while running. When it reaches zero the
//   timer either raises a sticky expiry flag that waits for an acknowledge
//   (AUTO_RELOAD=0), or reloads the last loaded value, pulses the expiry flag
//   for one cycle and keeps running (AUTO_RELOAD=1).
//
// Parameters:
//   WIDTH        counter / load value width in bits
//   AUTO_RELOAD  1 = reload the last loaded value on expiry and keep running
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   load          in   pulse: capture load_value into count and reload register
//   load_value    in   value captured on load
//   start         in   pulse: begin counting from the current count
//   enable        in   decrement qualifier while running
//   ack           in   clears expired (AUTO_RELOAD=0 only)
//   count         out  current count (registered)
//   busy          out  1 while running
//   zero_reached  out  combinational: count == 0
//   expired       out  expiry flag (registered)
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH       = 8,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             enable,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero_reached,
    output logic             expired
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_EXPIRED = 2'd2;

    localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_expired;

    // Count as seen by a start in IDLE: a load in the same cycle applies first.
    logic [WIDTH-1:0] w_idle_count;
    logic             w_terminal;

    always_comb begin
        w_idle_count = load ? load_value : r_count;
        w_terminal   = enable && (r_count == W_ONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_expired <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_count  <= load_value;
                        r_reload <= load_value;
                    end
                    if (start && (w_idle_count != '0)) begin
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    // Drops the one-cycle auto-reload pulse; already 0 otherwise.
                    r_expired <= 1'b0;
                    if (load) begin
                        // A load restarts the interval and wins over a terminal
                        // decrement in the same cycle.
                        r_count  <= load_value;
                        r_reload <= load_value;
                        if (load_value == '0) begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_terminal) begin
                        r_expired <= 1'b1;
                        if (AUTO_RELOAD != 0) begin
                            r_count <= r_reload;
                        end else begin
                            r_count <= '0;
                            r_state <= S_EXPIRED;
                        end
                    end else if (enable && (r_count != '0)) begin
                        r_count <= r_count - W_ONE;
                    end
                end

                S_EXPIRED: begin
                    if (load) begin
                        r_count  <= load_value;
                        r_reload <= load_value;
                    end
                    if (ack) begin
                        r_state   <= S_IDLE;
                        r_expired <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_expired <= 1'b0;
                end
            endcase
        end
    end

    assign count        = r_count;
    assign busy         = (r_state == S_RUN);
    assign zero_reached = (r_count == '0);
    assign expired      = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Purpose:
//   Directed self-checking bench for countdown_timer. One instance runs with
//   AUTO_RELOAD=0 (expiry handshake), a second with AUTO_RELOAD=1 (periodic
//   reload). Inputs change 1 ns after a rising edge and outputs are sampled
//   there, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // One-shot instance stimulus / observation
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             start = 1'b0;
    logic             enable = 1'b0;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             zero_reached;
    logic             expired;

    // Auto-reload instance stimulus / observation
    logic             a_reset = 1'b1;
    logic             a_load = 1'b0;
    logic [WIDTH-1:0] a_load_value = '0;
    logic             a_start = 1'b0;
    logic             a_enable = 1'b0;
    logic             a_ack = 1'b0;
    logic [WIDTH-1:0] a_count;
    logic             a_busy;
    logic             a_zero_reached;
    logic             a_expired;

    int n_vec  = 0;
    int n_fail = 0;

    countdown_timer #(.WIDTH(WIDTH), .AUTO_RELOAD(0)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_value   (load_value),
        .start        (start),
        .enable       (enable),
        .ack          (ack),
        .count        (count),
        .busy         (busy),
        .zero_reached (zero_reached),
        .expired      (expired)
    );

    countdown_timer #(.WIDTH(WIDTH), .AUTO_RELOAD(1)) u_dut_ar (
        .clk          (clk),
        .reset        (a_reset),
        .load         (a_load),
        .load_value   (a_load_value),
        .start        (a_start),
        .enable       (a_enable),
        .ack          (a_ack),
        .count        (a_count),
        .busy         (a_busy),
        .zero_reached (a_zero_reached),
        .expired      (a_expired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks all four outputs of the one-shot instance.
    task automatic chk_all(input string tag, input int e_cnt, input bit e_busy,
                           input bit e_exp);
        chk({tag, ".count"}, 32'(count), 32'(e_cnt));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".expired"}, 32'(expired), 32'(e_exp));
        chk({tag, ".zero"}, 32'(zero_reached), 32'(e_cnt == 0));
    endtask

    int e_cnt;
    bit e_pulse;

    initial begin
        // ---------------- 1. reset then idle ----------------
        tick();
        reset   = 1'b0;
        a_reset = 1'b0;
        repeat (5) tick();
        chk_all("t1_reset", 0, 1'b0, 1'b0);

        // ---------------- 2. load 5, run to expiry, hold, ack ----------------
        load = 1'b1; load_value = 8'd5;
        tick();
        load = 1'b0;
        chk_all("t2_load", 5, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0; enable = 1'b1;
        chk_all("t2_start", 5, 1'b1, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk_all($sformatf("t2_run%0d", i), i, (i != 0), (i == 0));
        end
        enable = 1'b0;
        repeat (10) tick();
        chk_all("t2_hold", 0, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t2_start_in_exp", 0, 1'b0, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("t2_ack", 0, 1'b0, 1'b0);

        // ---------------- 3. gated decrement ----------------
        load = 1'b1; load_value = 8'd4; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        chk_all("t3_start", 4, 1'b1, 1'b0);
        e_cnt = 4;
        for (int i = 0; i < 8; i++) begin
            enable = (i % 2 == 0);
            tick();
            if (enable && e_cnt > 0) e_cnt--;
            chk_all($sformatf("t3_cyc%0d", i), e_cnt, (e_cnt != 0), (e_cnt == 0));
        end
        enable = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("t3_ack", 0, 1'b0, 1'b0);

        // ---------------- 4. reload while running ----------------
        load = 1'b1; load_value = 8'd4; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0; enable = 1'b1;
        repeat (2) tick();
        chk_all("t4_at2", 2, 1'b1, 1'b0);
        load = 1'b1; load_value = 8'd7;
        tick();
        load = 1'b0;
        chk_all("t4_load7", 7, 1'b1, 1'b0);
        repeat (6) tick();
        chk_all("t4_at1", 1, 1'b1, 1'b0);
        load = 1'b1; load_value = 8'd3;
        tick();
        load = 1'b0;
        chk_all("t4_load_vs_terminal", 3, 1'b1, 1'b0);
        enable = 1'b0;
        load = 1'b1; load_value = 8'd0;
        tick();
        load = 1'b0;
        chk_all("t4_load0_in_run", 0, 1'b0, 1'b0);

        // ---------------- 5. ignored starts, reset mid-run ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t5_start_cnt0", 0, 1'b0, 1'b0);
        load = 1'b1; load_value = 8'd0; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        chk_all("t5_load0_start", 0, 1'b0, 1'b0);
        load = 1'b1; load_value = 8'd5; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0; enable = 1'b1;
        repeat (2) tick();
        chk_all("t5_at3", 3, 1'b1, 1'b0);
        reset = 1'b1; load = 1'b1; load_value = 8'd9;
        tick();
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        chk_all("t5_reset_run", 0, 1'b0, 1'b0);

        // ---------------- load while expired stays expired ----------------
        load = 1'b1; load_value = 8'd1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0; enable = 1'b1;
        tick();
        enable = 1'b0;
        chk_all("tx_expire1", 0, 1'b0, 1'b1);
        load = 1'b1; load_value = 8'd6;
        tick();
        load = 1'b0;
        chk_all("tx_load_in_exp", 6, 1'b0, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("tx_ack", 6, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("tx_reset_idle", 0, 1'b0, 1'b0);

        // ---------------- 6. auto-reload ----------------
        chk("t6_reset.count", 32'(a_count), 32'd0);
        chk("t6_reset.zero", 32'(a_zero_reached), 32'd1);
        a_load = 1'b1; a_load_value = 8'd3;
        tick();
        a_load = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0; a_enable = 1'b1;
        chk("t6_start.count", 32'(a_count), 32'd3);
        chk("t6_start.busy", 32'(a_busy), 32'd1);
        e_cnt = 3;
        for (int i = 0; i < 10; i++) begin
            tick();
            e_pulse = (e_cnt == 1);
            e_cnt   = e_pulse ? 3 : e_cnt - 1;
            chk($sformatf("t6_cyc%0d.count", i), 32'(a_count), 32'(e_cnt));
            chk($sformatf("t6_cyc%0d.expired", i), 32'(a_expired), 32'(e_pulse));
            chk($sformatf("t6_cyc%0d.busy", i), 32'(a_busy), 32'd1);
        end
        a_enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
